// File: rtl/spi_file_loader.sv
// SPI file-download receiver: oversampled SPI, byte packing into DATA_W words, write FIFO, wr/ack memory port.
// Optional zero-fill of the rest of the load region: define SPI_FILE_LOADER_FILL_EN.
module spi_file_loader #(
  parameter int                ADDR_W     = 25,
  parameter int                DATA_W     = 8,
  parameter int                IDX_W      = 5,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 25'h010000,
  parameter logic [ADDR_W-1:0] IDX_STRIDE = 25'h100000,
  parameter int                FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] FILL_MASK  = 25'h0FFFFF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                spi_sck,
  input  logic                spi_ss,
  input  logic                spi_sdi,
  output logic                downloading,
  output logic [IDX_W-1:0]    index,
  output logic                overflow,
  output logic                wr,
  input  logic                ack,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   dout,
  output logic [DATA_W/8-1:0] be
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LANE_W = $clog2(BYTES) + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(BYTES);
  localparam logic [ADDR_W-1:0] ALIGN = ADDR_W'(BYTES - 1);

  localparam logic [7:0] CMD_INDEX = 8'h55;
  localparam logic [7:0] CMD_TX    = 8'h53;
  localparam logic [7:0] CMD_DATA  = 8'h54;

  generate
    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_data_w
      $error("DATA_W must be 8, 16 or 32");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2, at least 2");
    end
    if (IDX_W < 1 || IDX_W > 8) begin : g_bad_idx_w
      $error("IDX_W must be 1..8");
    end
    if (FILL_MASK == '0) begin : g_bad_fill_mask
      $error("FILL_MASK of zero leaves no region to fill");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_DRAIN = 2'd2
`ifdef SPI_FILE_LOADER_FILL_EN
    , S_FILL = 2'd3
`endif
  } state_t;

  // ---------------- SPI front end ----------------
  logic [1:0] sck_sync_reg, ss_sync_reg, sdi_sync_reg;
  logic       sck_prev_reg;
  logic [2:0] bit_cnt_reg;
  logic [6:0] shift_reg;
  logic       first_reg;
  logic [7:0] cmd_reg;
  logic       data_valid_reg;
  logic [7:0] data_byte_reg;

  logic sck_s, ss_s, sdi_s, sck_rise;
  assign sck_s    = sck_sync_reg[1];
  assign ss_s     = ss_sync_reg[1];
  assign sdi_s    = sdi_sync_reg[1];
  assign sck_rise = sck_s & ~sck_prev_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync_reg   <= '0;
      ss_sync_reg    <= 2'b11;
      sdi_sync_reg   <= '0;
      sck_prev_reg   <= 1'b0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      first_reg      <= 1'b1;
      cmd_reg        <= '0;
      data_valid_reg <= 1'b0;
      data_byte_reg  <= '0;
    end else begin
      sck_sync_reg   <= {sck_sync_reg[0], spi_sck};
      ss_sync_reg    <= {ss_sync_reg[0], spi_ss};
      sdi_sync_reg   <= {sdi_sync_reg[0], spi_sdi};
      sck_prev_reg   <= sck_s;
      data_valid_reg <= 1'b0;
      if (ss_s) begin
        // Deselect drops only the framing; command and download state persist.
        bit_cnt_reg <= '0;
        shift_reg   <= '0;
        first_reg   <= 1'b1;
      end else if (sck_rise) begin
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        shift_reg   <= {shift_reg[5:0], sdi_s};
        if (bit_cnt_reg == 3'd7) begin
          shift_reg <= '0;
          first_reg <= 1'b0;
          if (first_reg) begin
            cmd_reg <= {shift_reg, sdi_s};
          end else begin
            data_valid_reg <= 1'b1;
            data_byte_reg  <= {shift_reg, sdi_s};
          end
        end
      end
    end
  end

  // ---------------- Command / packing state machine ----------------
  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;
  logic [LANE_W-1:0]   lane_reg, lane_next;
  logic [DATA_W-1:0]   word_reg, word_next;
  logic [BYTES-1:0]    be_acc_reg, be_next;
  logic                overflow_reg, overflow_next;
  logic [IDX_W-1:0]    index_reg, index_next;

  logic                push_req, push_ok, start_evt;
  logic [ADDR_W-1:0]   push_addr;
  logic [DATA_W-1:0]   push_data;
  logic [BYTES-1:0]    push_be;

  logic [PTR_W-1:0]    wr_idx_reg, rd_idx_reg;
  logic [PTR_W:0]      count_reg;
  logic                fifo_full, fifo_empty, pop;
  logic [ADDR_W-1:0]   start_addr;

  assign fifo_full  = (count_reg == (PTR_W + 1)'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign pop        = !fifo_empty && ack;
  assign start_addr = (BASE_ADDR + ADDR_W'(index_reg) * IDX_STRIDE) & ~ALIGN;

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    lane_next     = lane_reg;
    word_next     = word_reg;
    be_next       = be_acc_reg;
    overflow_next = overflow_reg;
    index_next    = index_reg;
    push_req      = 1'b0;
    push_addr     = ptr_reg;
    push_data     = word_reg;
    push_be       = be_acc_reg;
    start_evt     = 1'b0;

    if (data_valid_reg) begin
      case (cmd_reg)
        CMD_INDEX: index_next = data_byte_reg[IDX_W-1:0];
        CMD_TX: begin
          // Both START and END close any partially filled word first.
          if (lane_reg != '0) begin
            push_req = 1'b1;
            ptr_next = ptr_reg + STEP;
          end
          lane_next = '0;
          word_next = '0;
          be_next   = '0;
          if (data_byte_reg[0]) begin
            ptr_next   = start_addr;
            start_evt  = 1'b1;
            state_next = S_RECV;
          end else begin
`ifdef SPI_FILE_LOADER_FILL_EN
            state_next = (index_reg == '0) ? S_FILL : S_DRAIN;
`else
            state_next = S_DRAIN;
`endif
          end
        end
        CMD_DATA: begin
          if (state_reg == S_RECV) begin
            for (int i = 0; i < BYTES; i++) begin
              if (lane_reg == LANE_W'(i)) begin
                word_next[8*i +: 8] = data_byte_reg;
                be_next[i]          = 1'b1;
              end
            end
            lane_next = lane_reg + LANE_W'(1);
            if (lane_next == LANE_W'(BYTES)) begin
              push_req  = 1'b1;
              push_data = word_next;
              push_be   = '1;
              ptr_next  = ptr_reg + STEP;
              lane_next = '0;
              word_next = '0;
              be_next   = '0;
            end
          end
        end
        default: ;
      endcase
    end else begin
      case (state_reg)
        S_DRAIN: if (fifo_empty) state_next = S_IDLE;
`ifdef SPI_FILE_LOADER_FILL_EN
        S_FILL: begin
          // Fill waits for FIFO space instead of dropping words.
          if ((ptr_reg & FILL_MASK) == '0) begin
            state_next = S_DRAIN;
          end else if (!fifo_full) begin
            push_req  = 1'b1;
            push_data = '0;
            push_be   = '1;
            ptr_next  = ptr_reg + STEP;
          end
        end
`endif
        default: ;
      endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
    push_ok = push_req && (!fifo_full || pop);
    if (push_req && !push_ok) overflow_next = 1'b1;
    if (start_evt) overflow_next = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      ptr_reg      <= '0;
      lane_reg     <= '0;
      word_reg     <= '0;
      be_acc_reg   <= '0;
      overflow_reg <= 1'b0;
      index_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      lane_reg     <= lane_next;
      word_reg     <= word_next;
      be_acc_reg   <= be_next;
      overflow_reg <= overflow_next;
      index_reg    <= index_next;
    end
  end

  // ---------------- Write FIFO ----------------
  logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [BYTES-1:0]  mem_be   [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_addr[wr_idx_reg] <= push_addr;
      mem_data[wr_idx_reg] <= push_data;
      mem_be[wr_idx_reg]   <= push_be;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx_reg <= '0;
      rd_idx_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_idx_reg <= wr_idx_reg + PTR_W'(1);
      if (pop)     rd_idx_reg <= rd_idx_reg + PTR_W'(1);
      count_reg <= count_reg + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop);
    end
  end

  // Head is read combinationally so wr rises the cycle after a push; zeroed when empty.
  assign wr          = !fifo_empty;
  assign addr        = fifo_empty ? '0 : mem_addr[rd_idx_reg];
  assign dout        = fifo_empty ? '0 : mem_data[rd_idx_reg];
  assign be          = fifo_empty ? '0 : mem_be[rd_idx_reg];
  assign downloading = (state_reg != S_IDLE);
  assign index       = index_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_spi_file_loader.sv
// Randomised self-checking bench for spi_file_loader (DATA_W=16, FIFO_DEPTH=4, FILL_MASK=0xF).
module tb_spi_file_loader;

  typedef struct packed {
    logic [24:0] a;
    logic [15:0] d;
    logic [1:0]  b;
  } wr_t;

`ifdef SPI_FILE_LOADER_FILL_EN
  localparam bit FILL_ON = 1'b1;
`else
  localparam bit FILL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_ss = 1'b1;
  logic        spi_sdi = 1'b0;
  logic        downloading;
  logic [4:0]  index;
  logic        overflow;
  logic        wr;
  logic        ack = 1'b0;
  logic [24:0] addr;
  logic [15:0] dout;
  logic [1:0]  be;

  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];
  wr_t obs_q[$];

  spi_file_loader #(
    .DATA_W(16),
    .FIFO_DEPTH(4),
    .FILL_MASK(25'h00000F)
  ) dut (
    .clk(clk), .reset_n(reset_n), .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_sdi(spi_sdi),
    .downloading(downloading), .index(index), .overflow(overflow), .wr(wr), .ack(ack),
    .addr(addr), .dout(dout), .be(be)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n === 1'b1 && wr === 1'b1 && ack === 1'b1) begin
      obs_q.push_back('{addr, dout, be});
      $display("write addr=%h data=%h be=%b", addr, dout, be);
    end
  end

  // Reference: little-endian 16-bit words from the byte stream starting at the index base address.
  function automatic void model_transfer(input int idx, input logic [7:0] bytes[$], input bit ended);
    logic [24:0] p;
    int n;
    n = bytes.size();
    p = 25'(32'h010000 + idx * 32'h100000);
    p[0] = 1'b0;
    for (int k = 0; k < n; k += 2) begin
      exp_q.push_back('{p, {(k + 1 < n) ? bytes[k+1] : 8'h00, bytes[k]}, (k + 1 < n) ? 2'b11 : 2'b01});
      p = p + 25'd2;
    end
    if (FILL_ON && ended && idx == 0) begin
      while ((p & 25'h00000F) != 0) begin
        exp_q.push_back('{p, 16'h0000, 2'b11});
        p = p + 25'd2;
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      spi_sdi = b[i];
      #40 spi_sck = 1'b1;
      #40 spi_sck = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] data[$]);
    spi_ss = 1'b0;
    #40;
    send_byte(cmd);
    foreach (data[i]) send_byte(data[i]);
    #40 spi_ss = 1'b1;
    #100;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((downloading !== 1'b0 || wr !== 1'b0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s idle timeout: downloading=%b wr=%b, required 0/0", tag, downloading, wr);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 7;
    if (downloading !== 1'b0) begin errors++; $display("FAIL reset downloading: got %b, expected 0", downloading); end
    if (index !== 5'd0)       begin errors++; $display("FAIL reset index: got %h, expected 0", index); end
    if (overflow !== 1'b0)    begin errors++; $display("FAIL reset overflow: got %b, expected 0", overflow); end
    if (wr !== 1'b0)          begin errors++; $display("FAIL reset wr: got %b, expected 0", wr); end
    if (addr !== 25'd0)       begin errors++; $display("FAIL reset addr: got %h, expected 0", addr); end
    if (dout !== 16'd0)       begin errors++; $display("FAIL reset dout: got %h, expected 0", dout); end
    if (be !== 2'd0)          begin errors++; $display("FAIL reset be: got %b, expected 0", be); end
  endtask

  task automatic test_index;
    logic [7:0] q[$];
    for (int t = 0; t < 3; t++) begin
      q = {};
      for (int k = 0; k < 1 + t; k++) q.push_back(8'($urandom));
      send_frame(8'h55, q);
      checks++;
      if (index !== q[$][4:0]) begin
        errors++;
        $display("FAIL index %0d: got %h, expected %h", t, index, q[$][4:0]);
      end
    end
  endtask

  task automatic test_transfer;
    logic [7:0] q[$];
    logic [7:0] none[$];
    int idx;
    ack = 1'b1;
    for (int t = 0; t < 5; t++) begin
      q = {};
      if (t == 0) begin
        idx = 2;
        q = '{8'h11, 8'h22, 8'h33};
      end else begin
        idx = $urandom_range(0, 31);
        for (int k = 0; k < $urandom_range(1, 9); k++) q.push_back(8'($urandom));
      end
      exp_q = {};
      obs_q = {};
      send_frame(8'h55, '{8'(idx)});
      send_frame(8'h53, '{8'h01});
      checks++;
      if (downloading !== 1'b1) begin errors++; $display("FAIL xfer%0d downloading after START: got %b, expected 1", t, downloading); end
      send_frame(8'h54, q);
      none = '{8'h00};
      send_frame(8'h53, none);
      wait_idle("xfer");
      model_transfer(idx, q, 1'b1);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL xfer%0d write count: got %0d, expected %0d", t, obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
        checks++;
        if (obs_q[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL xfer%0d write %0d: got addr=%h data=%h be=%b, expected addr=%h data=%h be=%b",
                   t, k, obs_q[k].a, obs_q[k].d, obs_q[k].b, exp_q[k].a, exp_q[k].d, exp_q[k].b);
        end
      end
    end
  endtask

  task automatic test_overflow;
    logic [7:0] q[$];
    logic [7:0] kept[$];
    ack = 1'b0;
    exp_q = {};
    obs_q = {};
    for (int k = 0; k < 12; k++) q.push_back(8'($urandom));
    for (int k = 0; k < 8; k++) kept.push_back(q[k]);
    send_frame(8'h55, '{8'h03});
    send_frame(8'h53, '{8'h01});
    send_frame(8'h54, q);
    checks += 2;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf flag: got %b, expected 1", overflow); end
    if (wr !== 1'b1)       begin errors++; $display("FAIL ovf wr while stalled: got %b, expected 1", wr); end
    send_frame(8'h53, '{8'h00});
    @(posedge clk); #1 ack = 1'b1;
    wait_idle("ovf");
    model_transfer(3, kept, 1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ovf write count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL ovf write %0d: got addr=%h data=%h be=%b, expected addr=%h data=%h be=%b",
                 k, obs_q[k].a, obs_q[k].d, obs_q[k].b, exp_q[k].a, exp_q[k].d, exp_q[k].b);
      end
    end
    send_frame(8'h53, '{8'h01});
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf cleared by START: got %b, expected 0", overflow); end
    send_frame(8'h53, '{8'h00});
    wait_idle("ovf_end");
  endtask

  task automatic test_partial_ss;
    logic [7:0] q[$];
    ack = 1'b1;
    exp_q = {};
    obs_q = {};
    q = '{8'hC3, 8'h5A};
    send_frame(8'h53, '{8'h01});
    spi_ss = 1'b0;
    #40;
    send_byte(8'h54);
    for (int i = 0; i < 5; i++) begin
      spi_sdi = 1'b1;
      #40 spi_sck = 1'b1;
      #40 spi_sck = 1'b0;
    end
    #40 spi_ss = 1'b1;
    #100;
    send_frame(8'h54, q);
    send_frame(8'h53, '{8'h00});
    wait_idle("partial");
    model_transfer(3, q, 1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL partial write count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL partial write %0d: got addr=%h data=%h be=%b, expected addr=%h data=%h be=%b",
                 k, obs_q[k].a, obs_q[k].d, obs_q[k].b, exp_q[k].a, exp_q[k].d, exp_q[k].b);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int idx;
    ack = 1'b1;
    exp_q = {};
    obs_q = {};
    idx = $urandom_range(0, 31);
    for (int k = 0; k < 3; k++) q1.push_back(8'($urandom));
    for (int k = 0; k < 2; k++) q2.push_back(8'($urandom));
    send_frame(8'h55, '{8'(idx)});
    send_frame(8'h53, '{8'h01});
    send_frame(8'h54, q1);
    send_frame(8'h53, '{8'h01});
    send_frame(8'h54, q2);
    send_frame(8'h53, '{8'h00});
    wait_idle("b2b");
    model_transfer(idx, q1, 1'b0);
    model_transfer(idx, q2, 1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b write count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL b2b write %0d: got addr=%h data=%h be=%b, expected addr=%h data=%h be=%b",
                 k, obs_q[k].a, obs_q[k].d, obs_q[k].b, exp_q[k].a, exp_q[k].d, exp_q[k].b);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] q[$];
    ack = 1'b0;
    for (int k = 0; k < 6; k++) q.push_back(8'($urandom));
    send_frame(8'h55, '{8'h03});
    send_frame(8'h53, '{8'h01});
    send_frame(8'h54, q);
    checks++;
    if (wr !== 1'b1) begin errors++; $display("FAIL rstmid wr before reset: got %b, expected 1", wr); end
    #3 reset_n = 1'b0;
    #1;
    checks += 3;
    if (wr !== 1'b0)          begin errors++; $display("FAIL rstmid wr: got %b, expected 0", wr); end
    if (downloading !== 1'b0) begin errors++; $display("FAIL rstmid downloading: got %b, expected 0", downloading); end
    if (addr !== 25'd0)       begin errors++; $display("FAIL rstmid addr: got %h, expected 0", addr); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    ack = 1'b1;
    obs_q = {};
    repeat (20) @(posedge clk);
    #1;
    checks += 2;
    if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid writes after reset: got %0d, expected 0", obs_q.size()); end
    if (index !== 5'd0)    begin errors++; $display("FAIL rstmid index: got %h, expected 0", index); end
  endtask

  initial begin
    test_reset();
    test_index();
    test_transfer();
    test_overflow();
    test_partial_ss();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
